// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer for the 5-stage RV32I core
//
// Resolves load-use hazards, EX-stage redirects and multi-cycle LSU accesses
// and is the only source of stall/flush controls for the datapath.
//
// Ports:
//   i_clk, i_reset                     clock, asynchronous active-high reset
//   i_rs1/rs2_addr_id, i_rs1/rs2_used_id  ID-stage source registers and usage
//   i_rd_addr_ex, i_rd_wren_ex,
//   i_mem_ren_ex, i_insn_vld_ex        EX-stage destination and control bits
//   i_pc_sel_ex                        EX resolved a taken branch/jump
//   i_lsu_req_mem, i_lsu_ack           MEM-stage LSU request / completion
//   o_stall_*                          hold PC, IF/ID, ID/EX, EX/MEM
//   o_flush_if_id, o_flush_id_ex       insert a bubble
//   o_mispred                          redirect taken last cycle (registered)
//   o_mem_err                          sticky LSU timeout
//   o_stall_cnt, o_flush_cnt, o_wait_cnt  saturating statistics counters
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_rs1_addr_id,
  input  logic [4:0]       i_rs2_addr_id,
  input  logic             i_rs1_used_id,
  input  logic             i_rs2_used_id,
  input  logic [4:0]       i_rd_addr_ex,
  input  logic             i_rd_wren_ex,
  input  logic             i_mem_ren_ex,
  input  logic             i_insn_vld_ex,
  input  logic             i_pc_sel_ex,
  input  logic             i_lsu_req_mem,
  input  logic             i_lsu_ack,
  output logic             o_stall_pc,
  output logic             o_stall_if_id,
  output logic             o_stall_id_ex,
  output logic             o_stall_ex_mem,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_mispred,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_wait_cnt
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W:0] TIMEOUT_W = (WC_W + 1)'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_e;

  state_e            state_q;
  logic [WC_W-1:0]   wait_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              mispred_q;
  logic              mem_err_q;

  logic              lsu_pend;
  logic              freeze;
  logic              redir;
  logic              lu;
  logic              sel_redir;
  logic              sel_lu;
  logic [WC_W:0]     wait_inc;

  assign lsu_pend = i_lsu_req_mem & ~i_lsu_ack;
  // ERR keeps the whole pipeline frozen regardless of the LSU handshake.
  assign freeze   = (state_q == S_ERR) | lsu_pend;
  assign redir    = i_pc_sel_ex & i_insn_vld_ex;
  assign lu       = i_mem_ren_ex & i_rd_wren_ex & i_insn_vld_ex &
                    (i_rd_addr_ex != 5'd0) &
                    ((i_rs1_used_id & (i_rs1_addr_id == i_rd_addr_ex)) |
                     (i_rs2_used_id & (i_rs2_addr_id == i_rd_addr_ex)));

  // freeze > redir > lu; a frozen EX holds the branch, so the redirect is
  // simply taken on the first unfrozen cycle.
  assign sel_redir = ~freeze & redir;
  assign sel_lu    = ~freeze & ~redir & lu;

  assign o_stall_pc     = freeze | sel_lu;
  assign o_stall_if_id  = freeze | sel_lu;
  assign o_stall_id_ex  = freeze;
  assign o_stall_ex_mem = freeze;
  assign o_flush_if_id  = sel_redir;
  assign o_flush_id_ex  = sel_redir | sel_lu;

  assign o_mispred   = mispred_q;
  assign o_mem_err   = mem_err_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
  assign o_wait_cnt  = wait_cnt_q;

  // Value the wait counter takes after this MEM_WAIT cycle; ERR is entered
  // once it reaches MEM_TIMEOUT, i.e. after MEM_TIMEOUT frozen cycles.
  assign wait_inc = {1'b0, wait_q} + (WC_W + 1)'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      mispred_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      mispred_q <= sel_redir;
      if (sel_lu)    stall_cnt_q <= sat_inc(stall_cnt_q);
      if (sel_redir) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (lsu_pend && state_q != S_ERR) wait_cnt_q <= sat_inc(wait_cnt_q);

      case (state_q)
        S_RUN: begin
          if (lsu_pend) begin
            state_q <= S_MEM_WAIT;
            wait_q  <= WC_W'(1);
          end
        end
        S_MEM_WAIT: begin
          if (i_lsu_ack) begin
            state_q <= S_RUN;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_inc[WC_W-1:0];
            if (wait_inc >= TIMEOUT_W) begin
              state_q   <= S_ERR;
              mem_err_q <= 1'b1;
            end
          end
        end
        S_ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q <= S_RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W = 3;

  localparam logic [31:0] NONE = 32'b000000;
  localparam logic [31:0] FRZ  = 32'b111100;
  localparam logic [31:0] RED  = 32'b000011;
  localparam logic [31:0] LU   = 32'b110001;

  localparam int K_COMB = 0;
  localparam int K_MISP = 1;
  localparam int K_ERR  = 2;
  localparam int K_SC   = 3;
  localparam int K_FC   = 4;
  localparam int K_WC   = 5;

  logic             i_clk;
  logic             i_reset;
  logic [4:0]       i_rs1_addr_id, i_rs2_addr_id;
  logic             i_rs1_used_id, i_rs2_used_id;
  logic [4:0]       i_rd_addr_ex;
  logic             i_rd_wren_ex, i_mem_ren_ex, i_insn_vld_ex;
  logic             i_pc_sel_ex, i_lsu_req_mem, i_lsu_ack;
  logic             o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem;
  logic             o_flush_if_id, o_flush_id_ex;
  logic             o_mispred, o_mem_err;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt, o_wait_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_rs1_addr_id  (i_rs1_addr_id),
    .i_rs2_addr_id  (i_rs2_addr_id),
    .i_rs1_used_id  (i_rs1_used_id),
    .i_rs2_used_id  (i_rs2_used_id),
    .i_rd_addr_ex   (i_rd_addr_ex),
    .i_rd_wren_ex   (i_rd_wren_ex),
    .i_mem_ren_ex   (i_mem_ren_ex),
    .i_insn_vld_ex  (i_insn_vld_ex),
    .i_pc_sel_ex    (i_pc_sel_ex),
    .i_lsu_req_mem  (i_lsu_req_mem),
    .i_lsu_ack      (i_lsu_ack),
    .o_stall_pc     (o_stall_pc),
    .o_stall_if_id  (o_stall_if_id),
    .o_stall_id_ex  (o_stall_id_ex),
    .o_stall_ex_mem (o_stall_ex_mem),
    .o_flush_if_id  (o_flush_if_id),
    .o_flush_id_ex  (o_flush_id_ex),
    .o_mispred      (o_mispred),
    .o_mem_err      (o_mem_err),
    .o_stall_cnt    (o_stall_cnt),
    .o_flush_cnt    (o_flush_cnt),
    .o_wait_cnt     (o_wait_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_COMB: return {26'd0, o_stall_pc, o_stall_if_id, o_stall_id_ex,
                      o_stall_ex_mem, o_flush_if_id, o_flush_id_ex};
      K_MISP: return {31'd0, o_mispred};
      K_ERR:  return {31'd0, o_mem_err};
      K_SC:   return 32'(o_stall_cnt);
      K_FC:   return 32'(o_flush_cnt);
      K_WC:   return 32'(o_wait_cnt);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.kind);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s kind=%0d observed=%0h expected=%0h", e.tag, e.kind, o, e.val);
      end
    end
  endtask

  task automatic set_idle();
    i_rs1_addr_id = 5'd0; i_rs2_addr_id = 5'd0;
    i_rs1_used_id = 1'b0; i_rs2_used_id = 1'b0;
    i_rd_addr_ex  = 5'd0; i_rd_wren_ex  = 1'b0;
    i_mem_ren_ex  = 1'b0; i_insn_vld_ex = 1'b0;
    i_pc_sel_ex   = 1'b0; i_lsu_req_mem = 1'b0; i_lsu_ack = 1'b0;
  endtask

  // Load in EX writing rd, with the ID instruction's sources/usage.
  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    set_idle();
    i_rd_addr_ex  = rd;  i_rd_wren_ex = 1'b1; i_mem_ren_ex = 1'b1; i_insn_vld_ex = 1'b1;
    i_rs1_addr_id = rs1; i_rs2_addr_id = rs2;
    i_rs1_used_id = u1;  i_rs2_used_id = u2;
  endtask

  initial begin
    set_idle();
    i_reset = 1'b1;

    @(negedge i_clk);
    expect_v("reset_comb", K_COMB, NONE);
    expect_v("reset_misp", K_MISP, 0);
    expect_v("reset_err",  K_ERR,  0);
    expect_v("reset_sc",   K_SC,   0);
    expect_v("reset_fc",   K_FC,   0);
    expect_v("reset_wc",   K_WC,   0);
    check();
    i_reset = 1'b0;

    // load-use on rs1
    @(negedge i_clk); set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    expect_v("lu_rs1", K_COMB, LU); expect_v("lu_sc0", K_SC, 0); check();
    @(negedge i_clk); set_idle();
    expect_v("lu_after", K_COMB, NONE); expect_v("lu_sc1", K_SC, 1); check();

    // rs2 matches but unused; load to x0
    @(negedge i_clk); set_lu(5'd5, 5'd3, 5'd5, 1'b1, 1'b0);
    expect_v("rs2_unused", K_COMB, NONE); check();
    @(negedge i_clk); set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    expect_v("rd_x0", K_COMB, NONE); expect_v("rs2_unused_sc", K_SC, 1); check();

    // redirect beats load-use
    @(negedge i_clk); set_lu(5'd5, 5'd5, 5'd5, 1'b1, 1'b1); i_pc_sel_ex = 1'b1;
    expect_v("redir_over_lu", K_COMB, RED); expect_v("rd_x0_sc", K_SC, 1);
    expect_v("redir_fc0", K_FC, 0); check();
    @(negedge i_clk); set_idle();
    expect_v("redir_after", K_COMB, NONE); expect_v("redir_misp", K_MISP, 1);
    expect_v("redir_fc1", K_FC, 1); expect_v("redir_sc", K_SC, 1); check();
    @(negedge i_clk);
    expect_v("misp_clear", K_MISP, 0); check();

    // LSU wait of 3 cycles with a pending redirect
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk); set_idle();
      i_lsu_req_mem = 1'b1; i_pc_sel_ex = 1'b1; i_insn_vld_ex = 1'b1;
      expect_v("wait_frz", K_COMB, FRZ); expect_v("wait_wc", K_WC, i);
      expect_v("wait_misp", K_MISP, 0); check();
    end
    @(negedge i_clk); i_lsu_ack = 1'b1;
    expect_v("ack_redir", K_COMB, RED); expect_v("ack_wc", K_WC, 3); check();
    @(negedge i_clk); set_idle();
    expect_v("post_ack", K_COMB, NONE); expect_v("post_ack_wc", K_WC, 3);
    expect_v("post_ack_fc", K_FC, 2); expect_v("post_ack_misp", K_MISP, 1); check();

    // same-cycle ack never freezes
    @(negedge i_clk); i_lsu_req_mem = 1'b1; i_lsu_ack = 1'b1;
    expect_v("same_ack", K_COMB, NONE); check();
    @(negedge i_clk); set_idle();
    expect_v("same_ack_after", K_COMB, NONE); expect_v("same_ack_wc", K_WC, 3); check();

    // clear statistics before the timeout scenario
    i_reset = 1'b1;
    expect_v("rst2_wc", K_WC, 0); expect_v("rst2_fc", K_FC, 0); check();
    i_reset = 1'b0;

    // timeout: MEM_TIMEOUT = 4, ack never arrives
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); set_idle(); i_lsu_req_mem = 1'b1;
      expect_v("to_frz", K_COMB, FRZ); expect_v("to_wc", K_WC, i);
      expect_v("to_err0", K_ERR, 0); check();
    end
    @(negedge i_clk);
    expect_v("err_frz", K_COMB, FRZ); expect_v("err_set", K_ERR, 1);
    expect_v("err_wc", K_WC, 4); check();
    @(negedge i_clk); set_idle(); i_pc_sel_ex = 1'b1; i_insn_vld_ex = 1'b1;
    expect_v("err_hold", K_COMB, FRZ); expect_v("err_sticky", K_ERR, 1);
    expect_v("err_wc_hold", K_WC, 4); check();
    @(negedge i_clk); set_idle();
    expect_v("err_idle_frz", K_COMB, FRZ); expect_v("err_no_fc", K_FC, 0);
    expect_v("err_no_misp", K_MISP, 0); expect_v("err_wc_hold2", K_WC, 4); check();

    // asynchronous reset mid-ERR, between clock edges
    @(posedge i_clk); #2; i_reset = 1'b1;
    expect_v("async_rst_comb", K_COMB, NONE); expect_v("async_rst_err", K_ERR, 0);
    expect_v("async_rst_wc", K_WC, 0); check();
    @(negedge i_clk); i_reset = 1'b0;
    @(negedge i_clk);
    expect_v("post_rst_run", K_COMB, NONE); expect_v("post_rst_err", K_ERR, 0); check();

    // saturation of the 3-bit stall counter
    for (int i = 0; i < 9; i++) begin
      @(negedge i_clk); set_lu(5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
      expect_v("sat_lu", K_COMB, LU); expect_v("sat_sc", K_SC, (i < 7) ? i : 7); check();
    end
    @(negedge i_clk); set_idle();
    expect_v("sat_final", K_SC, 7); expect_v("sat_idle", K_COMB, NONE); check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencer for the 5-stage RV32I core. It resolves load-use hazards, control redirects and multi-cycle LSU accesses by driving the stall and flush inputs of the PC and the IF/ID, ID/EX and EX/MEM registers. It also keeps stall and flush statistics and a sticky LSU-timeout error. It sits beside the datapath in `pipelined` and is the only source of stall and flush signals.

## Interface
- `MEM_TIMEOUT`, default 16: maximum consecutive LSU wait cycles before error.
- `CNT_W`, default 32: width of the statistics counters.

- `i_clk`  in  1  core clock
- `i_reset`  in  1  reset; asynchronous, active-high
- `i_rs1_addr_id`, `i_rs2_addr_id`  in  5 each  source registers of the ID instruction
- `i_rs1_used_id`, `i_rs2_used_id`  in  1 each  ID instruction actually reads rs1 / rs2
- `i_rd_addr_ex`  in  5  destination register in EX
- `i_rd_wren_ex`, `i_mem_ren_ex`, `i_insn_vld_ex`  in  1 each  EX-stage control bits
- `i_pc_sel_ex`  in  1  EX resolved a taken branch or jump (redirect)
- `i_lsu_req_mem`  in  1  MEM stage holds a valid load or store
- `i_lsu_ack`  in  1  LSU completes the access this cycle
- `o_stall_pc`, `o_stall_if_id`, `o_stall_id_ex`, `o_stall_ex_mem`  out  1 each  hold the register
- `o_flush_if_id`, `o_flush_id_ex`  out  1 each  load a bubble (valid=0)
- `o_mispred`  out  1  registered: a redirect was taken last cycle
- `o_mem_err`  out  1  sticky LSU timeout
- `o_stall_cnt`  out  CNT_W  load-use stall cycles
- `o_flush_cnt`  out  CNT_W  redirects taken
- `o_wait_cnt`  out  CNT_W  LSU freeze cycles

## Operation
- FSM states:
  - RUN (reset state)
  - MEM_WAIT
  - ERR
- Combinational terms:
  - `freeze` = (`i_lsu_req_mem` & !`i_lsu_ack`) in RUN or MEM_WAIT; forced to 1 in ERR.
  - `lu` = `i_mem_ren_ex` & `i_rd_wren_ex` & `i_insn_vld_ex` & (`i_rd_addr_ex` != 0) & ((`i_rs1_used_id` & rs1 == rd) | (`i_rs2_used_id` & rs2 == rd)).
  - `redir` = `i_pc_sel_ex` & `i_insn_vld_ex`.
- Strict priority between the three terms: freeze > redir > lu.
  - freeze: all four stalls = 1, all flushes = 0. Redirect and load-use evaluation are deferred because EX is held.
  - redir: `o_flush_if_id` = `o_flush_id_ex` = 1, all stalls = 0, so the PC loads the target. Any lu is ignored because the ID instruction is squashed.
  - lu: `o_stall_pc` = `o_stall_if_id` = 1 and `o_flush_id_ex` = 1 (one bubble). `o_stall_id_ex` = `o_stall_ex_mem` = 0.
  - None: all outputs 0.
- The stall for lu lasts exactly one cycle. After the bubble the load is in MEM, and the existing forwarding network covers the dependency.
- Transitions:
  - RUN → MEM_WAIT when `i_lsu_req_mem` & !`i_lsu_ack`; the wait counter loads 1.
  - MEM_WAIT → RUN when `i_lsu_ack`.
  - MEM_WAIT → ERR when the wait counter reaches MEM_TIMEOUT without ack; the counter otherwise increments each cycle.
  - ERR is terminal until reset. `o_mem_err` = 1 and the pipeline stays frozen.
- A request acknowledged in the same cycle it appears causes no freeze and no state change.
- Counters:
  - Each saturates at all-ones.
  - `o_stall_cnt` increments on lu-selected cycles.
  - `o_flush_cnt` increments on redir-selected cycles.
  - `o_wait_cnt` increments on freeze cycles in RUN/MEM_WAIT; it does not count in ERR.
- `o_mispred` is the redir-selected term registered one cycle. Static not-taken prediction applies, so every redirect is a mispredict.

## Timing
- Reset (async): state = RUN, wait counter = 0, all counters = 0, `o_mispred` = 0, `o_mem_err` = 0. Stall and flush outputs are combinational and evaluate to 0 while the inputs are idle.
- Stall and flush outputs are combinational from the inputs and state, with zero latency. They take effect at the next `i_clk` edge.
- `o_mispred`, `o_mem_err` and the counters update on the `i_clk` edge after the qualifying cycle.
- Reset asserted during MEM_WAIT or ERR returns the block to RUN immediately. The wait counter clears.
- A redirect and an LSU freeze in the same cycle: the freeze wins. The redirect is taken on the first unfrozen cycle because EX still holds the branch.
- The rd = x0 load never stalls.

## Test plan
- Load-use: `lw x5` in EX with `i_mem_ren_ex` = 1, ID `add` with rs1 = x5 used → one cycle of stall_pc = stall_if_id = flush_id_ex = 1; `o_stall_cnt` = 1 on the next cycle, then all signals 0.
- Unused-field and x0 checks: rs2 = x5 but `i_rs2_used_id` = 0 (I-type) → no stall. Load to rd = x0 with rs1 = x0 → no stall.
- Redirect vs. load-use: `i_pc_sel_ex` = 1 and lu true in the same cycle → flush_if_id = flush_id_ex = 1, no stalls; `o_mispred` = 1 and `o_flush_cnt` = 1 one cycle later.
- LSU wait: `i_lsu_req_mem` = 1 with ack low for 3 cycles, then ack → all four stalls high for exactly 3 cycles, state returns to RUN, `o_wait_cnt` = 3. A simultaneous `i_pc_sel_ex` is deferred and flushes on the ack cycle.
- Timeout: MEM_TIMEOUT = 4, ack never arrives → ERR after the 4th wait cycle, `o_mem_err` = 1 and stalls held. Asserting `i_reset` mid-ERR clears everything immediately.
- Saturation: CNT_W = 3 with 9 load-use events → `o_stall_cnt` holds at 7.
